// File: rtl/ime_partition_cost_accumulator_pkg.sv
// Shared definitions for the IME partition cost accumulator: FSM state
// encodings, sub-block count, Z-order quadrant mapping and default widths.
// COST_W defaults to the codebase IME cost width (16).
package ime_partition_cost_accumulator_pkg;

  localparam int IME_COST_W_DEF = 16;
  localparam int IME_SUB_W_DEF  = 12;

  // Sub-blocks per CU and the index of the final beat.
  localparam int         IME_SUB_BLK_NUM  = 16;
  localparam logic [3:0] IME_SUB_BLK_LAST = 4'(IME_SUB_BLK_NUM - 1);

  typedef enum logic [1:0] {
    IME_ACC_IDLE  = 2'd0,
    IME_ACC_ACCUM = 2'd1,
    IME_ACC_HOLD  = 2'd2
  } ime_acc_state_e;

  // Z-order: the top two index bits select the quadrant (0 TL, 1 TR, 2 BL, 3 BR).
  function automatic logic [1:0] ime_quad_of(input logic [3:0] idx);
    return idx[3:2];
  endfunction

endpackage

// File: rtl/ime_partition_cost_accumulator_if.sv
// Sub-block input stream and cost-bundle output of the partition cost
// accumulator. slave = the accumulator, master = its environment.
interface ime_partition_cost_accumulator_if
  import ime_partition_cost_accumulator_pkg::*;
#(
  parameter int SUB_W  = IME_SUB_W_DEF,
  parameter int COST_W = IME_COST_W_DEF
);
  logic              start_i;
  logic [5:0]        part_x_i;
  logic [5:0]        part_y_i;
  logic              sub_val_i;
  logic [SUB_W-1:0]  sub_cst_i;
  logic              sub_rdy_o;
  logic              dat_val_o;
  logic              dat_rdy_i;
  logic [COST_W-1:0] dat_1nx1n_cst_0_o;
  logic [COST_W-1:0] dat_1nx1n_cst_1_o;
  logic [COST_W-1:0] dat_1nx1n_cst_2_o;
  logic [COST_W-1:0] dat_1nx1n_cst_3_o;
  logic [COST_W-1:0] dat_1nx2n_cst_0_o;
  logic [COST_W-1:0] dat_1nx2n_cst_1_o;
  logic [COST_W-1:0] dat_2nx1n_cst_0_o;
  logic [COST_W-1:0] dat_2nx1n_cst_1_o;
  logic [COST_W-1:0] dat_2nx2n_cst_o;
  logic [5:0]        part_x_o;
  logic [5:0]        part_y_o;
  logic              err_o;

  modport slave (
    input  start_i, part_x_i, part_y_i, sub_val_i, sub_cst_i, dat_rdy_i,
    output sub_rdy_o, dat_val_o,
           dat_1nx1n_cst_0_o, dat_1nx1n_cst_1_o, dat_1nx1n_cst_2_o, dat_1nx1n_cst_3_o,
           dat_1nx2n_cst_0_o, dat_1nx2n_cst_1_o, dat_2nx1n_cst_0_o, dat_2nx1n_cst_1_o,
           dat_2nx2n_cst_o, part_x_o, part_y_o, err_o
  );

  modport master (
    output start_i, part_x_i, part_y_i, sub_val_i, sub_cst_i, dat_rdy_i,
    input  sub_rdy_o, dat_val_o,
           dat_1nx1n_cst_0_o, dat_1nx1n_cst_1_o, dat_1nx1n_cst_2_o, dat_1nx1n_cst_3_o,
           dat_1nx2n_cst_0_o, dat_1nx2n_cst_1_o, dat_2nx1n_cst_0_o, dat_2nx1n_cst_1_o,
           dat_2nx2n_cst_o, part_x_o, part_y_o, err_o
  );
endinterface

// File: rtl/ime_partition_cost_accumulator_sat.sv
// ime_cost_sat: reduces a wide cost sum to COST_W bits.
// IME_PART_COST_SAT_EN defined  : clamp to 2^OUT_W-1 (decision engine convention).
// IME_PART_COST_SAT_EN undefined: keep the low OUT_W bits (wrap).
module ime_cost_sat #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  sum_i,
  output logic [OUT_W-1:0] cost_o
);
  localparam int EXT_W = (IN_W > OUT_W) ? IN_W : OUT_W;

  logic [EXT_W-1:0] sum_ext;
  assign sum_ext = EXT_W'(sum_i);

`ifdef IME_PART_COST_SAT_EN
  localparam logic [EXT_W-1:0] COST_MAX = EXT_W'({OUT_W{1'b1}});
  // Clamp anything above the largest representable cost.
  assign cost_o = (sum_ext > COST_MAX) ? OUT_W'(COST_MAX) : OUT_W'(sum_ext);
`else
  // Wrap: the integration keeps sums narrow enough that nothing is lost.
  assign cost_o = OUT_W'(sum_ext);
`endif
endmodule

// File: rtl/ime_partition_cost_accumulator.sv
// IME partition cost accumulator: folds 16 Z-order sub-block costs of a CU
// into quadrant, half and full CU costs and presents them as one registered
// bundle tagged with part_x/part_y. Output reduction is selected by the
// IME_PART_COST_SAT_EN macro (saturate when defined, wrap otherwise).
module ime_partition_cost_accumulator
  import ime_partition_cost_accumulator_pkg::*;
#(
  parameter int COST_W = IME_COST_W_DEF,
  parameter int SUB_W  = IME_SUB_W_DEF
) (
  input  logic                            clk,
  input  logic                            rst,
  ime_partition_cost_accumulator_if.slave bus
);
  localparam int Q_W = SUB_W + 2;
  localparam int H_W = SUB_W + 3;
  localparam int F_W = SUB_W + 4;

  ime_acc_state_e    state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [Q_W-1:0]    acc_q [4];
  logic [Q_W-1:0]    acc_d [4];
  logic [H_W-1:0]    half_sum [4];
  logic [F_W-1:0]    full_sum;
  logic [COST_W-1:0] cost_d [9];
  logic [COST_W-1:0] cost_q [9];
  logic [5:0]        tag_x_q, tag_y_q, part_x_q, part_y_q;
  logic              dat_val_q, err_q, err_d;
  logic              sub_rdy, beat, hs, start_cu, add_beat, load_out;

  // Ready passes straight through from the consumer while a bundle is held.
  always_comb begin
    sub_rdy = (state_q == IME_ACC_HOLD) ? bus.dat_rdy_i : 1'b1;
    beat    = bus.sub_val_i & sub_rdy;
    hs      = dat_val_q & bus.dat_rdy_i;
  end

  // Next-state and control decode for IDLE / ACCUM / HOLD.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d  = state_q;
    start_cu = 1'b0;
    add_beat = 1'b0;
    load_out = 1'b0;
    err_d    = 1'b0;
    unique case (state_q)
      IME_ACC_IDLE: begin
        if (beat) begin
          if (bus.start_i) begin
            start_cu = 1'b1;
            state_d  = IME_ACC_ACCUM;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      IME_ACC_ACCUM: begin
        if (beat) begin
          if (bus.start_i) begin
            start_cu = 1'b1;
            err_d    = 1'b1;
          end else begin
            add_beat = 1'b1;
            if (cnt_q == IME_SUB_BLK_LAST) begin
              load_out = 1'b1;
              state_d  = IME_ACC_HOLD;
            end
          end
        end
      end
      IME_ACC_HOLD: begin
        if (hs) begin
          state_d = IME_ACC_IDLE;
          if (beat && bus.start_i) begin
            start_cu = 1'b1;
            state_d  = IME_ACC_ACCUM;
          end else if (beat) begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IME_ACC_IDLE;
    endcase
  end

  // Accumulator update: a start beat seeds quadrant 0, later beats add to cnt[3:2].
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (start_cu) begin
      for (int k = 0; k < 4; k++) acc_d[k] = '0;
      acc_d[0] = Q_W'(bus.sub_cst_i);
      cnt_d    = 4'd1;
    end else if (add_beat) begin
      acc_d[ime_quad_of(cnt_q)] = acc_q[ime_quad_of(cnt_q)] + Q_W'(bus.sub_cst_i);
      cnt_d                     = cnt_q + 4'd1;
    end
  end

  // Half and full sums taken from the post-update accumulators so the last beat counts.
  always_comb begin
    half_sum[0] = H_W'(acc_d[0]) + H_W'(acc_d[2]);
    half_sum[1] = H_W'(acc_d[1]) + H_W'(acc_d[3]);
    half_sum[2] = H_W'(acc_d[0]) + H_W'(acc_d[1]);
    half_sum[3] = H_W'(acc_d[2]) + H_W'(acc_d[3]);
    full_sum    = F_W'(half_sum[0]) + F_W'(half_sum[1]);
  end

  for (genvar g = 0; g < 4; g++) begin : g_quad
    ime_cost_sat #(.IN_W(Q_W), .OUT_W(COST_W)) u_sat (.sum_i(acc_d[g]), .cost_o(cost_d[g]));
  end
  for (genvar g = 0; g < 4; g++) begin : g_half
    ime_cost_sat #(.IN_W(H_W), .OUT_W(COST_W)) u_sat (.sum_i(half_sum[g]), .cost_o(cost_d[4+g]));
  end
  ime_cost_sat #(.IN_W(F_W), .OUT_W(COST_W)) u_sat_full (.sum_i(full_sum), .cost_o(cost_d[8]));

  // Datapath working registers, seeded by every start beat before use.
  always_ff @(posedge clk) begin
    // NOTE: accumulators and the tag capture carry no reset; a start beat always overwrites them.
    acc_q <= acc_d;
    if (start_cu) begin
      tag_x_q <= bus.part_x_i;
      tag_y_q <= bus.part_y_i;
    end
  end

  // Control state and the registered output bundle, synchronously reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q   <= IME_ACC_IDLE;
      cnt_q     <= '0;
      dat_val_q <= 1'b0;
      err_q     <= 1'b0;
      part_x_q  <= '0;
      part_y_q  <= '0;
      for (int k = 0; k < 9; k++) cost_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (load_out) begin
        dat_val_q <= 1'b1;
        cost_q    <= cost_d;
        part_x_q  <= tag_x_q;
        part_y_q  <= tag_y_q;
      end else if (hs) begin
        dat_val_q <= 1'b0;
      end
    end
  end

  assign bus.sub_rdy_o         = sub_rdy;
  assign bus.dat_val_o         = dat_val_q;
  assign bus.err_o             = err_q;
  assign bus.part_x_o          = part_x_q;
  assign bus.part_y_o          = part_y_q;
  assign bus.dat_1nx1n_cst_0_o = cost_q[0];
  assign bus.dat_1nx1n_cst_1_o = cost_q[1];
  assign bus.dat_1nx1n_cst_2_o = cost_q[2];
  assign bus.dat_1nx1n_cst_3_o = cost_q[3];
  assign bus.dat_1nx2n_cst_0_o = cost_q[4];
  assign bus.dat_1nx2n_cst_1_o = cost_q[5];
  assign bus.dat_2nx1n_cst_0_o = cost_q[6];
  assign bus.dat_2nx1n_cst_1_o = cost_q[7];
  assign bus.dat_2nx2n_cst_o   = cost_q[8];
endmodule
